xadac_vload_mem: RTL and testbench

XADAC_VLOAD_MEM -- requirements
Module: xadac_vload_mem

---
 rtl/xadac_vload_mem_if.sv | 36 +++
 rtl/xadac_vload_mem.sv | 101 ++++++++++
 tb/tb_xadac_vload_mem.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/xadac_vload_mem_if.sv
// xadac_vload_mem_if: AR/R vector read channels plus narrow memory request/response port.
// Ports (slave = load unit view):
//   axi_ar_id/addr/valid in, axi_ar_ready out   -- vector read request
//   axi_r_id/data/valid out, axi_r_ready in     -- assembled vector response
//   mem_req/addr out, mem_gnt in                -- per-beat memory request
//   mem_rvalid/rdata in                         -- in-order memory read data
interface xadac_vload_mem_if #(
    parameter int IdWidth      = 4,
    parameter int AddrWidth    = 32,
    parameter int VecDataWidth = 128,
    parameter int MemDataWidth = 32
);
    logic [IdWidth-1:0]      axi_ar_id;
    logic [AddrWidth-1:0]    axi_ar_addr;
    logic                    axi_ar_valid;
    logic                    axi_ar_ready;
    logic [IdWidth-1:0]      axi_r_id;
    logic [VecDataWidth-1:0] axi_r_data;
    logic                    axi_r_valid;
    logic                    axi_r_ready;
    logic                    mem_req;
    logic [AddrWidth-1:0]    mem_addr;
    logic                    mem_gnt;
    logic                    mem_rvalid;
    logic [MemDataWidth-1:0] mem_rdata;

    modport slave (
        input  axi_ar_id, axi_ar_addr, axi_ar_valid, axi_r_ready, mem_gnt, mem_rvalid, mem_rdata,
        output axi_ar_ready, axi_r_id, axi_r_data, axi_r_valid, mem_req, mem_addr
    );

    modport master (
        output axi_ar_id, axi_ar_addr, axi_ar_valid, axi_r_ready, mem_gnt, mem_rvalid, mem_rdata,
        input  axi_ar_ready, axi_r_id, axi_r_data, axi_r_valid, mem_req, mem_addr
    );
endinterface

// File: rtl/xadac_vload_mem.sv
// xadac_vload_mem: splits each vector read into Beats narrow memory reads and returns the assembled vector.
// Ports: clk, rstn (async active-low), bus (xadac_vload_mem_if.slave: AR in, R out, memory port).
// Interface instance parameters must match IdWidth/AddrWidth/VecDataWidth/MemDataWidth here.
module xadac_vload_mem #(
    parameter int MemDataWidth = 32,
    parameter int FifoDepth    = 2,
    parameter int VecDataWidth = 128,
    parameter int IdWidth      = 4,
    parameter int AddrWidth    = 32
) (
    input logic              clk,
    input logic              rstn,
    xadac_vload_mem_if.slave bus
);
    localparam int Beats    = VecDataWidth / MemDataWidth;
    localparam int CntW     = $clog2(Beats) + 1;
    localparam int IdxW     = Beats > 1 ? $clog2(Beats) : 1;
    localparam int PtrW     = $clog2(FifoDepth);
    localparam int VecBytes = VecDataWidth / 8;
    localparam int MemShift = $clog2(MemDataWidth / 8);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

    state_t state, state_nxt;
    logic [IdWidth-1:0]   fifo_id   [FifoDepth];
    logic [AddrWidth-1:0] fifo_addr [FifoDepth];
    logic [PtrW:0]        wr_ptr, rd_ptr;
    logic                 ready_en, full, empty, push, pop;
    logic                 gnt_fire, rsp_fire, last_gnt, last_rsp;
    logic [AddrWidth-1:0] base;
    logic [CntW-1:0]      req_cnt, rsp_cnt;
    logic [Beats-1:0][MemDataWidth-1:0] data;

    // Extra pointer MSB distinguishes full from empty; ready_en keeps ar_ready low until the first edge after reset.
    assign full     = (wr_ptr ^ rd_ptr) == {1'b1, {PtrW{1'b0}}};
    assign empty    = wr_ptr == rd_ptr;
    assign bus.axi_ar_ready = ready_en && !full;
    assign push     = bus.axi_ar_valid && bus.axi_ar_ready;
    assign pop      = state == RSP && bus.axi_r_ready;
    assign gnt_fire = state == REQ && bus.mem_gnt;
    assign rsp_fire = (state == REQ || state == WAIT) && bus.mem_rvalid && rsp_cnt < CntW'(Beats);
    assign last_gnt = gnt_fire && req_cnt == CntW'(Beats - 1);
    assign last_rsp = rsp_fire && rsp_cnt == CntW'(Beats - 1);

    assign bus.mem_req     = state == REQ;
    assign bus.mem_addr    = state == REQ ? base + (AddrWidth'(req_cnt) << MemShift) : '0;
    assign bus.axi_r_valid = state == RSP;
    assign bus.axi_r_id    = state == RSP ? fifo_id[rd_ptr[PtrW-1:0]] : '0;
    assign bus.axi_r_data  = state == RSP ? data : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = empty ? IDLE : REQ;
            REQ:     state_nxt = last_rsp ? RSP : last_gnt ? WAIT : REQ;
            WAIT:    state_nxt = last_rsp ? RSP : WAIT;
            RSP:     state_nxt = bus.axi_r_ready ? IDLE : RSP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_en <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            base     <= '0;
            req_cnt  <= '0;
            rsp_cnt  <= '0;
            data     <= '0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (state == IDLE && !empty) begin
                base    <= fifo_addr[rd_ptr[PtrW-1:0]] & ~AddrWidth'(VecBytes - 1);
                req_cnt <= '0;
                rsp_cnt <= '0;
                data    <= '0;
            end
            if (gnt_fire) req_cnt <= req_cnt + 1'b1;
            if (rsp_fire) begin
                data[rsp_cnt[IdxW-1:0]] <= bus.mem_rdata;
                rsp_cnt <= rsp_cnt + 1'b1;
            end
        end
    end

    // Request storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wr_ptr[PtrW-1:0]]   <= bus.axi_ar_id;
            fifo_addr[wr_ptr[PtrW-1:0]] <= bus.axi_ar_addr;
        end
    end
endmodule

// File: tb/tb_xadac_vload_mem.sv
// tb_xadac_vload_mem: scoreboard bench for the vector load unit with a behavioural memory model.
module tb_xadac_vload_mem;
    typedef struct packed {
        logic [3:0]   id;
        logic [127:0] data;
    } rsp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    xadac_vload_mem_if #(.IdWidth(4), .AddrWidth(32), .VecDataWidth(128), .MemDataWidth(32)) bus ();

    xadac_vload_mem #(
        .MemDataWidth(32), .FifoDepth(2), .VecDataWidth(128), .IdWidth(4), .AddrWidth(32)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    rsp_t        exp_r[$];
    logic [31:0] exp_addr[$];
    logic [31:0] mem_q[$];
    int          cmp_cnt = 0;
    int          err_cnt = 0;
    int          stall = 0;
    int          stall_cnt = 0;
    int          gnt_cnt = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_data = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        cmp_cnt++;
        err_cnt++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Memory: grants after `stall` waiting cycles, returns the next queued word the cycle after the grant.
    always @(negedge clk) begin
        if (!rstn) begin
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            pend           = 1'b0;
            stall_cnt      = 0;
        end else begin
            bus.mem_rvalid = pend;
            bus.mem_rdata  = pend_data;
            pend           = 1'b0;
            bus.mem_gnt    = 1'b0;
            if (bus.mem_req) begin
                if (exp_addr.size() == 0) fail_now("mem_req_unexpected");
                else chk("mem_addr", bus.mem_addr, exp_addr[0]);
                if (stall_cnt < stall) stall_cnt++;
                else begin
                    bus.mem_gnt = 1'b1;
                    stall_cnt   = 0;
                    pend        = 1'b1;
                    pend_data   = mem_q.size() != 0 ? mem_q.pop_front() : 32'hDEAD_BEEF;
                    if (exp_addr.size() != 0) void'(exp_addr.pop_front());
                    gnt_cnt++;
                end
            end
        end
    end

    // R monitor: every valid cycle must match the scoreboard head, which also proves stability under stall.
    always @(negedge clk) begin
        if (rstn && bus.axi_r_valid) begin
            if (exp_r.size() == 0) fail_now("r_valid_unexpected");
            else begin
                chk("r_id", 128'(bus.axi_r_id), 128'(exp_r[0].id));
                chk("r_data", bus.axi_r_data, exp_r[0].data);
                if (bus.axi_r_ready) void'(exp_r.pop_front());
            end
        end
    end

    task automatic expect_rd(input logic [3:0] id, input logic [31:0] addr,
                             input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] b;
        b = addr & ~32'hF;
        for (int i = 0; i < 4; i++) exp_addr.push_back(b + 32'(i * 4));
        mem_q.push_back(w0);
        mem_q.push_back(w1);
        mem_q.push_back(w2);
        mem_q.push_back(w3);
        exp_r.push_back({id, w3, w2, w1, w0});
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, output int waited);
        bus.axi_ar_id    = id;
        bus.axi_ar_addr  = addr;
        bus.axi_ar_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!bus.axi_ar_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) fail_now("ar_accept");
        @(posedge clk);
        #1 bus.axi_ar_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_r.size() != 0 || exp_addr.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) fail_now("drain");
        chk("mem_words_used", 128'(mem_q.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ar_ready", 128'(bus.axi_ar_ready), 128'd0);
        chk("rst_r_valid", 128'(bus.axi_r_valid), 128'd0);
        chk("rst_r_id", 128'(bus.axi_r_id), 128'd0);
        chk("rst_r_data", bus.axi_r_data, 128'd0);
        chk("rst_mem_req", 128'(bus.mem_req), 128'd0);
        chk("rst_mem_addr", 128'(bus.mem_addr), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        int g0;
        bus.axi_ar_valid = 1'b0;
        bus.axi_ar_id    = '0;
        bus.axi_ar_addr  = '0;
        bus.axi_r_ready  = 1'b1;
        bus.mem_gnt      = 1'b0;
        bus.mem_rvalid   = 1'b0;
        bus.mem_rdata    = '0;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rstn = 1'b1;
        @(posedge clk);
        #1 chk("ar_ready_after_reset", 128'(bus.axi_ar_ready), 128'd1);

        // Single read with latency check: R valid in the 7th cycle after acceptance.
        expect_rd(4'd3, 32'h1008, 32'h11, 32'h22, 32'h33, 32'h44);
        chk("expected_vector", exp_r[0].data, 128'h00000044_00000033_00000022_00000011);
        send_ar(4'd3, 32'h1008, w);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.axi_r_valid && n < 50);
        chk("rd_latency", 128'(n), 128'd7);
        drain();

        // Back-pressure: R held for 5 cycles, second AR fills the FIFO.
        bus.axi_r_ready = 1'b0;
        expect_rd(4'd4, 32'h2000, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
        send_ar(4'd4, 32'h2000, w);
        expect_rd(4'd5, 32'h2014, 32'hB1, 32'hB2, 32'hB3, 32'hB4);
        send_ar(4'd5, 32'h2014, w);
        chk("second_ar_no_wait", 128'(w), 128'd0);
        n = 0;
        while (!bus.axi_r_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ar_ready_full", 128'(bus.axi_ar_ready), 128'd0);
        repeat (5) @(posedge clk);
        #1 bus.axi_r_ready = 1'b1;
        drain();

        // Grant stalls: 3 idle cycles before each grant, address held meanwhile.
        stall = 3;
        expect_rd(4'd7, 32'h300C, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 32'hC0DE_0004);
        send_ar(4'd7, 32'h300C, w);
        drain();
        stall = 0;

        // Back-to-back: third AR must wait for FIFO space; responses stay in order.
        expect_rd(4'd0, 32'h0040, 32'h0000_0100, 32'h0000_0101, 32'h0000_0102, 32'h0000_0103);
        expect_rd(4'd1, 32'h0050, 32'h0000_0110, 32'h0000_0111, 32'h0000_0112, 32'h0000_0113);
        expect_rd(4'd2, 32'hFFFF_FFF8, 32'h0000_0120, 32'h0000_0121, 32'h0000_0122, 32'h0000_0123);
        send_ar(4'd0, 32'h0040, w);
        send_ar(4'd1, 32'h0050, w);
        send_ar(4'd2, 32'hFFFF_FFF8, w);
        chk("third_ar_waited", 128'(w != 0), 128'd1);
        drain();

        // Reset after two grants: outputs clear at once, next read completes cleanly.
        g0 = gnt_cnt;
        expect_rd(4'd9, 32'h4000, 32'h9990, 32'h9991, 32'h9992, 32'h9993);
        send_ar(4'd9, 32'h4000, w);
        n = 0;
        while (gnt_cnt < g0 + 2 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n >= 100) fail_now("two_grants");
        #2 rstn = 1'b0;
        #1 chk_reset_outputs();
        exp_r.delete();
        exp_addr.delete();
        mem_q.delete();
        repeat (2) @(negedge clk);
        chk("ar_ready_in_reset", 128'(bus.axi_ar_ready), 128'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1 chk("ar_ready_after_rerst", 128'(bus.axi_ar_ready), 128'd1);
        expect_rd(4'd10, 32'h5004, 32'h5550, 32'h5551, 32'h5552, 32'h5553);
        send_ar(4'd10, 32'h5004, w);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
